// File: rtl/shared_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : shared_reg_pkg
// Purpose  : Shared constants and helpers for the shared-register arbiter.
//            N_DEF/DW_DEF/CW_DEF are the default requester count, data width
//            and contention-counter width. rr_next() is the modulo-N
//            round-robin pointer increment.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shared_reg_pkg;

  localparam int N_DEF  = 2;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 8;

  // The compare-and-wrap form keeps the result in range for
  // non-power-of-2 N. A plain ID_W-bit add would run past N-1.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : shared_reg_arbiter_if
// Purpose   : Bundles the requester-side request/data bus and the arbiter's
//             shared-register outputs.
// Signals   : req[N]        requests, held until acked
//             wdata[N*DW]   per-requester write data, lane i at [i*DW +: DW]
//             ack[N]        one-hot registered grant pulse
//             data_out[DW]  the shared register
//             valid_out     a write has occurred since reset
//             last_id[ID_W] index of the most recent writer
//             conflict_cnt  saturating count of contended cycles
// Modports  : master (requester side), slave (arbiter side)
// Revision  : 1.0 - initial release
// ============================================================================
interface shared_reg_arbiter_if
  import shared_reg_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic [ID_W-1:0] last_id;
  logic [CW-1:0]   conflict_cnt;

  modport master (
    output req, wdata,
    input  ack, data_out, valid_out, last_id, conflict_cnt
  );

  modport slave (
    input  req, wdata,
    output ack, data_out, valid_out, last_id, conflict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Purely combinational round-robin picker. It returns the first
//            eligible index, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Ports    : elig_i[N]        eligible requesters
//            ptr_i[ID_W]      search start index (always < N)
//            gnt_onehot_o[N]  one-hot winner (zero if none)
//            gnt_id_o[ID_W]   winner index (zero if none)
//            any_o            at least one requester is eligible
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    elig_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_onehot_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  // The loop walks the search order backwards, so the candidate closest
  // to ptr is written last and wins.
  always_comb begin
    int idx;
    gnt_onehot_o = '0;
    gnt_id_o     = '0;
    any_o        = 1'b0;
    idx          = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (elig_i[idx]) begin
        gnt_onehot_o      = '0;
        gnt_onehot_o[idx] = 1'b1;
        gnt_id_o          = ID_W'(idx);
        any_o             = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_reg_arbiter
// Purpose  : Round-robin write arbiter for one shared register. At most one
//            requester writes per cycle. A requester that is being acked is
//            masked out for that cycle. The block also tracks the last
//            writer and counts contended cycles, saturating at 2^CW-1.
// Ports    : clk    rising-edge clock
//            rst_n  synchronous active-low reset
//            bus    shared_reg_arbiter_if.slave (req/wdata in;
//                   ack/data_out/valid_out/last_id/conflict_cnt out)
// Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_reg_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    ack_q, ack_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    elig;
  logic [N-1:0]    gnt_onehot;
  logic [ID_W-1:0] gnt_id;
  logic            any;
  logic            contention;

  // Masking the requester acked this cycle prevents a second write
  // from one request while that requester is still dropping req.
  assign elig = bus.req & ~ack_q;

  // popcount(elig) >= 2 is the same as "more than one bit set".
  assign contention = (elig & (elig - N'(1))) != '0;

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .elig_i       (elig),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_id_o     (gnt_id),
    .any_o        (any)
  );

  always_comb begin
    ack_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (any) begin
      // Only the winning lane is read, so X on idle lanes cannot leak.
      ack_d   = gnt_onehot;
      data_d  = bus.wdata[int'(gnt_id)*DW +: DW];
      valid_d = 1'b1;
      last_d  = gnt_id;
      ptr_d   = ID_W'(rr_next(int'(gnt_id), N));
    end
    if (contention && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.last_id      = last_q;
  assign bus.conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_reg_arbiter
// Purpose  : Self-checking bench for shared_reg_arbiter. It uses two
//            instances (N=2/CW=8 and N=3/CW=2) and compares both against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst3_n;

  shared_reg_arbiter_if #(.N(2), .DW(8), .CW(8)) bus2 ();
  shared_reg_arbiter_if #(.N(3), .DW(8), .CW(2)) bus3 ();

  shared_reg_arbiter #(.N(2), .DW(8), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  shared_reg_arbiter #(.N(3), .DW(8), .CW(2)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, indexed by instance (0: N=2, 1: N=3).
  int m_ptr   [2];
  int m_ack   [2];
  int m_data  [2];
  int m_valid [2];
  int m_last  [2];
  int m_cnt   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Applies one clock edge to the model, following the arbitration rules.
  task automatic model_edge(input int u, input int n, input int cw, input bit rstn,
                            input logic [7:0] rq, input logic [23:0] wd);
    int win;
    int ne;
    int i;
    if (!rstn) begin
      m_ptr[u] = 0; m_ack[u] = 0; m_data[u] = 0;
      m_valid[u] = 0; m_last[u] = 0; m_cnt[u] = 0;
    end else begin
      win = -1;
      ne  = 0;
      for (int j = 0; j < n; j++)
        if (rq[j] && (((m_ack[u] >> j) & 1) == 0)) ne++;
      for (int k = 0; k < n; k++) begin
        i = (m_ptr[u] + k) % n;
        if (win < 0 && rq[i] && (((m_ack[u] >> i) & 1) == 0)) win = i;
      end
      if (ne >= 2 && m_cnt[u] < (1 << cw) - 1) m_cnt[u]++;
      if (win >= 0) begin
        m_data[u]  = int'(wd[win*8 +: 8]);
        m_ack[u]   = 1 << win;
        m_last[u]  = win;
        m_valid[u] = 1;
        m_ptr[u]   = (win + 1) % n;
      end else begin
        m_ack[u] = 0;
      end
    end
  endtask

  task automatic cmp2();
    check("n2_ack",   32'(bus2.ack),          m_ack[0]);
    check("n2_data",  32'(bus2.data_out),     m_data[0]);
    check("n2_valid", 32'(bus2.valid_out),    m_valid[0]);
    check("n2_last",  32'(bus2.last_id),      m_last[0]);
    check("n2_cnt",   32'(bus2.conflict_cnt), m_cnt[0]);
  endtask

  task automatic cmp3();
    check("n3_ack",   32'(bus3.ack),          m_ack[1]);
    check("n3_data",  32'(bus3.data_out),     m_data[1]);
    check("n3_valid", 32'(bus3.valid_out),    m_valid[1]);
    check("n3_last",  32'(bus3.last_id),      m_last[1]);
    check("n3_cnt",   32'(bus3.conflict_cnt), m_cnt[1]);
  endtask

  task automatic step2(input bit rstn);
    rst_n = rstn;
    model_edge(0, 2, 8, rstn, {6'b0, bus2.req}, {8'h00, bus2.wdata});
    @(posedge clk);
    #1;
    cmp2();
  endtask

  task automatic step3(input bit rstn);
    rst3_n = rstn;
    model_edge(1, 3, 2, rstn, {5'b0, bus3.req}, bus3.wdata);
    @(posedge clk);
    #1;
    cmp3();
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; rst3_n = 1'b0;
    bus2.req = '0; bus2.wdata = '0;
    bus3.req = '0; bus3.wdata = '0;
    @(posedge clk); #1;

    // Reset while both requesters are asking.
    bus2.req = 2'b11; bus2.wdata = 16'h2211;
    step2(1'b0); step2(1'b0);
    check("rst_data",  32'(bus2.data_out),     32'h0);
    check("rst_ack",   32'(bus2.ack),          32'h0);
    check("rst_valid", 32'(bus2.valid_out),    32'h0);
    check("rst_cnt",   32'(bus2.conflict_cnt), 32'h0);

    // A single request is granted on the next edge.
    bus2.req = 2'b01; bus2.wdata = 16'h00A5;
    step2(1'b1);
    check("single_ack",   32'(bus2.ack),       32'h1);
    check("single_data",  32'(bus2.data_out),  32'hA5);
    check("single_valid", 32'(bus2.valid_out), 32'h1);
    check("single_last",  32'(bus2.last_id),   32'h0);
    bus2.req = 2'b00;
    step2(1'b1);
    check("single_ackoff", 32'(bus2.ack),      32'h0);
    check("single_hold",   32'(bus2.data_out), 32'hA5);

    // Simultaneous requests, starting from ptr=0.
    step2(1'b0);
    bus2.req = 2'b11; bus2.wdata = 16'h2211;
    step2(1'b1);
    check("simul1_data", 32'(bus2.data_out),     32'h11);
    check("simul1_ack",  32'(bus2.ack),          32'h1);
    check("simul1_cnt",  32'(bus2.conflict_cnt), 32'h1);
    bus2.req = 2'b10;
    step2(1'b1);
    check("simul2_data", 32'(bus2.data_out),     32'h22);
    check("simul2_ack",  32'(bus2.ack),          32'h2);
    check("simul2_last", 32'(bus2.last_id),      32'h1);
    check("simul2_cnt",  32'(bus2.conflict_cnt), 32'h1);
    bus2.req = 2'b00;
    step2(1'b1);

    // Continuous contention: each requester re-asserts with new data in
    // its ack cycle. Grants alternate, and a reset lands while ptr=1.
    step2(1'b0);
    d = 8'h40;
    bus2.req = 2'b11; bus2.wdata = {d + 8'h80, d};
    for (int k = 0; k < 8; k++) begin
      step2(1'b1);
      check("cont_last", 32'(bus2.last_id), 32'(k % 2));
      d = d + 8'h1;
      if (bus2.ack[0]) bus2.wdata[7:0]  = d;
      if (bus2.ack[1]) bus2.wdata[15:8] = d + 8'h80;
      if (k == 4) begin
        step2(1'b0);
        check("midrst_ack",   32'(bus2.ack),       32'h0);
        check("midrst_valid", 32'(bus2.valid_out), 32'h0);
        step2(1'b1);
        check("midrst_first", 32'(bus2.ack), 32'h1);
        break;
      end
    end

    // Randomized traffic with occasional resets. Idle lanes carry X.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (bus2.req[i] && (((m_ack[0] >> i) & 1) == 0)) begin
          if ($urandom_range(15) == 0) begin
            bus2.req[i] = 1'b0;
            bus2.wdata[i*8 +: 8] = 8'hxx;
          end
        end else begin
          bus2.req[i] = 1'($urandom_range(1));
          bus2.wdata[i*8 +: 8] = bus2.req[i] ? 8'($urandom) : 8'hxx;
        end
      end
      step2($urandom_range(39) != 0);
    end

    // Saturation with N=3, CW=2: all three requesters re-assert continuously.
    bus3.req = 3'b111;
    bus3.wdata = 24'($urandom);
    step3(1'b0);
    for (int k = 0; k < 10; k++) begin
      step3(1'b1);
      for (int i = 0; i < 3; i++)
        if (bus3.ack[i]) bus3.wdata[i*8 +: 8] = 8'($urandom);
    end
    check("sat_cnt", 32'(bus3.conflict_cnt), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
